// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link blocks.
// Holds the FSM encoding and bit-order constants.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit MSB = 1'b1;
  localparam bit LSB = 1'b0;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word
// holding buffer for gapless back-to-back frames.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = MSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx;
  logic             accept;
  logic             at_end;

  assign in_ready = !full_q;
  assign accept   = in_valid && in_ready;
  assign at_end   = shift_en && (cnt_q == LAST_CNT);

  assign idx = (MSB_FIRST == MSB) ? (LAST_CNT - cnt_q) : cnt_q;

  assign serial_valid = (state_q == ST_SHIFT);
  assign serial_out   = serial_valid && sr_q[idx];
  assign last         = serial_valid && (cnt_q == LAST_CNT);
  assign busy         = serial_valid || full_q;

  // State, shift register, counter and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load, advance, refill from buffer or bypass.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    buf_d   = buf_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d    = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + CW'(1);
          end else if (full_q) begin
            sr_d   = buf_q;
            cnt_d  = '0;
            full_d = 1'b0;
          end else if (accept) begin
            sr_d  = in_data;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // A word arriving mid-frame parks in the buffer.
        if (accept && !at_end) begin
          buf_d  = in_data;
          full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer against a
// word-queue reference model, both bit orders at once.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         shift_en;

  logic rdy_m, so_m, sv_m, last_m, busy_m;
  logic rdy_l, so_l, sv_l, last_l, busy_l;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  int           pos = 0;

  logic [31:0] cap_m, cap_l, last_cap;
  int          vcnt;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .shift_en(shift_en),
    .serial_out(so_m), .serial_valid(sv_m),
    .last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .shift_en(shift_en),
    .serial_out(so_l), .serial_valid(sv_l),
    .last(last_l), .busy(busy_l)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic         v;
    logic [W-1:0] w;
    logic         lst;
    v   = mq.size() > 0;
    w   = v ? mq[0] : '0;
    lst = v && (pos == W - 1);
    check("in_ready_m", 32'(rdy_m), 32'(mq.size() < 2));
    check("in_ready_l", 32'(rdy_l), 32'(mq.size() < 2));
    check("valid_m", 32'(sv_m), 32'(v));
    check("valid_l", 32'(sv_l), 32'(v));
    check("bit_m", 32'(so_m), 32'(v && w[W-1-pos]));
    check("bit_l", 32'(so_l), 32'(v && w[pos]));
    check("last_m", 32'(last_m), 32'(lst));
    check("last_l", 32'(last_l), 32'(lst));
    check("busy_m", 32'(busy_m), 32'(v));
    check("busy_l", 32'(busy_l), 32'(v));
  endtask

  task automatic step(input logic v,
                      input logic [W-1:0] d,
                      input logic se);
    logic acc;
    in_valid = v;
    in_data  = d;
    shift_en = se;
    acc = v && (mq.size() < 2);
    @(posedge clk);
    if (se && mq.size() > 0) begin
      pos++;
      if (pos == W) begin
        mq.delete(0);
        pos = 0;
      end
    end
    if (acc) mq.push_back(d);
    @(negedge clk);
    check_outputs();
    cap_m    = {cap_m[30:0], so_m};
    cap_l    = {cap_l[30:0], so_l};
    last_cap = {last_cap[30:0], last_m};
    vcnt     = vcnt + int'(sv_m);
  endtask

  task automatic clear_cap();
    cap_m    = '0;
    cap_l    = '0;
    last_cap = '0;
    vcnt     = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * W; i++) begin
      if (mq.size() == 0) break;
      step(1'b0, '0, 1'b1);
    end
    check("drained", 32'(busy_m), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_m", 32'(so_m), 32'd0);
    check("rst_valid_m", 32'(sv_m), 32'd0);
    check("rst_valid_l", 32'(sv_l), 32'd0);
    check("rst_last_m", 32'(last_m), 32'd0);
    check("rst_busy_m", 32'(busy_m), 32'd0);
    check("rst_busy_l", 32'(busy_l), 32'd0);
    check("rst_ready_m", 32'(rdy_m), 32'd1);
    check("rst_ready_l", 32'(rdy_l), 32'd1);
    mq.delete();
    pos      = 0;
    in_valid = 1'b0;
    shift_en = 1'b0;
    in_data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic         hv;
    logic [W-1:0] hd;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b0;
    in_data  = '0;
    clear_cap();
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check_outputs();

    // single frame, MSB and LSB first
    clear_cap();
    step(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check("single_msb", cap_m[3:0], 32'b1011);
    check("single_lsb", cap_l[3:0], 32'b1101);
    check("single_last", last_cap[3:0], 32'b0001);
    step(1'b0, '0, 1'b1);
    check("single_idle", 32'(sv_m), 32'd0);

    // back-to-back frames through the buffer
    clear_cap();
    step(1'b1, 4'b1011, 1'b1);
    step(1'b1, 4'b0110, 1'b1);
    check("b2b_notready", 32'(rdy_m), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check("b2b_msb", cap_m[7:0], 32'b10110110);
    check("b2b_lsb", cap_l[7:0], 32'b11010110);
    check("b2b_last", last_cap[7:0], 32'b00010001);
    check("b2b_valid", 32'(vcnt), 32'd8);
    drain();

    // paced by shift_en every third cycle
    clear_cap();
    step(1'b1, 4'b1011, 1'b0);
    for (int k = 1; k <= 14; k++)
      step(1'b0, '0, (k % 3) == 0);
    check("pace_span", 32'(vcnt), 32'd12);

    // abort with a buffered word pending
    step(1'b1, 4'b1011, 1'b1);
    step(1'b1, 4'b0110, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    clear_cap();
    step(1'b1, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check("abort_msb", cap_m[3:0], 32'b0001);
    check("abort_lsb", cap_l[3:0], 32'b1000);
    check("abort_last", last_cap[3:0], 32'b0001);
    drain();

    // random traffic; source holds an unaccepted word
    hv = 1'b0;
    hd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!(hv && !rdy_m)) begin
        hv = ($urandom % 2) == 0;
        hd = W'($urandom);
      end
      step(hv, hd, ($urandom % 4) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
